// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback
// sources, plus a clear sequencer that rewrites the x1..x31 reset image.
module regfile_write_arbiter #(
  parameter int unsigned NREQ       = 3,
  parameter logic [4:0]  SP_INDEX   = 5'd2,
  parameter logic [31:0] STACK_INIT = 32'h0000_3FFC
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic [NREQ-1:0]      iReqValid,
  input  logic [5*NREQ-1:0]    iReqAddr,
  input  logic [32*NREQ-1:0]   iReqData,
  output logic [NREQ-1:0]      oReqGrant,
  input  logic                 iClearReq,
  output logic                 oBusy,
  output logic                 oRegWrite,
  output logic [4:0]           oWriteRegister,
  output logic [31:0]          oWriteData
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW = PW + 1;
  localparam logic [AW-1:0] LAST_REG = 5'd31;

  typedef enum logic {
    ST_ARB,
    ST_CLEAR
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          wr_nxt;
  logic [AW-1:0] waddr_nxt;
  logic [DW-1:0] wdata_nxt;

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];
  logic          found;
  logic [PW-1:0] sel;
  logic [SW-1:0] sum;

  // Unpack the flat requester buses.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_arr[i] = iReqAddr[i*AW +: AW];
      data_arr[i] = iReqData[i*DW +: DW];
    end
  end

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      if (!found && iReqValid[sum[PW-1:0]]) begin
        found = 1'b1;
        sel   = sum[PW-1:0];
      end
    end
  end

  assign oBusy = (state == ST_CLEAR);

  // Next-state, grant and write-port staging.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    wr_nxt    = 1'b0;
    waddr_nxt = oWriteRegister;
    wdata_nxt = oWriteData;
    oReqGrant = '0;
    case (state)
      ST_ARB: begin
        if (iClearReq) begin
          cnt_nxt   = 5'd1;
          state_nxt = ST_CLEAR;
        end else if (found && iRST_N) begin
          oReqGrant[sel] = 1'b1;
          ptr_nxt   = (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);
          // x0 is hardwired: the handshake completes but nothing is written.
          wr_nxt    = (addr_arr[sel] != '0);
          waddr_nxt = addr_arr[sel];
          wdata_nxt = data_arr[sel];
        end
      end
      ST_CLEAR: begin
        wr_nxt    = 1'b1;
        waddr_nxt = cnt;
        wdata_nxt = (cnt == SP_INDEX) ? STACK_INIT : '0;
        if (cnt == LAST_REG) begin
          cnt_nxt   = '0;
          state_nxt = ST_ARB;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state          <= ST_ARB;
      ptr            <= '0;
      cnt            <= '0;
      oRegWrite      <= 1'b0;
      oWriteRegister <= '0;
      oWriteData     <= '0;
    end else begin
      state          <= state_nxt;
      ptr            <= ptr_nxt;
      cnt            <= cnt_nxt;
      oRegWrite      <= wr_nxt;
      oWriteRegister <= waddr_nxt;
      oWriteData     <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus queues expected grants and
// writes, a negedge monitor pops and compares whatever the DUT presents.
module tb_regfile_write_arbiter;

  localparam int unsigned NREQ = 3;

  logic              iCLK = 1'b0;
  logic              iRST_N;
  logic [NREQ-1:0]   iReqValid;
  logic [5*NREQ-1:0] iReqAddr;
  logic [32*NREQ-1:0] iReqData;
  logic [NREQ-1:0]   oReqGrant;
  logic              iClearReq;
  logic              oBusy;
  logic              oRegWrite;
  logic [4:0]        oWriteRegister;
  logic [31:0]       oWriteData;

  regfile_write_arbiter #(
    .NREQ(NREQ),
    .SP_INDEX(5'd2),
    .STACK_INIT(32'h0000_3FFC)
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iReqValid(iReqValid),
    .iReqAddr(iReqAddr),
    .iReqData(iReqData),
    .oReqGrant(oReqGrant),
    .iClearReq(iClearReq),
    .oBusy(oBusy),
    .oRegWrite(oRegWrite),
    .oWriteRegister(oWriteRegister),
    .oWriteData(oWriteData)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } wexp_t;

  wexp_t           wq[$];
  logic [NREQ-1:0] gq[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  // Monitor: every grant and every write must match the head of its queue.
  always @(negedge iCLK) begin
    if (iRST_N) begin
      if (oReqGrant != '0) begin
        n_cmp++;
        if (gq.size() == 0) begin
          n_fail++;
          $display("FAIL grant: got %b at cycle %0d, expected none", oReqGrant, cyc);
        end else begin
          logic [NREQ-1:0] g;
          g = gq.pop_front();
          if (oReqGrant !== g) begin
            n_fail++;
            $display("FAIL grant: got %b, expected %b (cycle %0d)", oReqGrant, g, cyc);
          end
        end
      end
      if (oRegWrite) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL write: got reg=%0d data=%h at cycle %0d, expected none",
                   oWriteRegister, oWriteData, cyc);
        end else begin
          wexp_t e;
          e = wq.pop_front();
          if (oWriteRegister !== e.a || oWriteData !== e.d || cyc != e.c) begin
            n_fail++;
            $display("FAIL write: got reg=%0d data=%h cycle=%0d, expected reg=%0d data=%h cycle=%0d",
                     oWriteRegister, oWriteData, cyc, e.a, e.d, e.c);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    iReqValid[i]        = v;
    iReqAddr[i*5 +: 5]  = a;
    iReqData[i*32 +: 32] = d;
  endtask

  task automatic push_grant(input logic [NREQ-1:0] g, input logic [4:0] a,
                            input logic [31:0] d, input logic wr);
    gq.push_back(g);
    if (wr) wq.push_back('{a, d, cyc + 1});
  endtask

  // Clear launched in cycle n0 writes xk in cycle n0+k+1.
  task automatic push_clear(input int n0);
    for (int k = 1; k <= 31; k++) begin
      logic [31:0] dv;
      dv = (k == 2) ? 32'h0000_3FFC : 32'h0;
      wq.push_back('{5'(k), dv, n0 + k + 1});
    end
  endtask

  logic [31:0] rr_data [3];

  initial begin
    int n0;
    rr_data[0] = 32'hA000_0000;
    rr_data[1] = 32'hB111_1111;
    rr_data[2] = 32'hC222_2222;
    iRST_N    = 1'b0;
    iClearReq = 1'b0;
    iReqValid = '0;
    iReqAddr  = '0;
    iReqData  = '0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(10 + i), rr_data[i]);

    // Reset with all requesters valid
    repeat (3) @(negedge iCLK);
    check("reset_grant", 32'(oReqGrant), 32'h0);
    check("reset_regwrite", 32'(oRegWrite), 32'h0);
    check("reset_busy", 32'(oBusy), 32'h0);
    check("reset_wreg", 32'(oWriteRegister), 32'h0);
    check("reset_wdata", oWriteData, 32'h0);

    // Round-robin from pointer 0
    tick();
    iRST_N = 1'b1;
    for (int n = 0; n < 6; n++) begin
      push_grant(3'(1 << (n % 3)), 5'(10 + n % 3), rr_data[n % 3], 1'b1);
      tick();
    end
    iReqValid = '0;
    tick();

    // Single requester 1
    set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    push_grant(3'b010, 5'd5, 32'hDEAD_BEEF, 1'b1);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    tick();

    // Write to x0 is dropped but the pointer still moves past requester 0
    set_req(0, 1'b1, 5'd0, 32'h0000_1234);
    push_grant(3'b001, 5'd0, 32'h0000_1234, 1'b0);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    @(negedge iCLK);
    check("x0_no_write", 32'(oRegWrite), 32'h0);
    tick();
    set_req(0, 1'b1, 5'd3, 32'h3333_0000);
    set_req(1, 1'b1, 5'd4, 32'h4444_0000);
    push_grant(3'b010, 5'd4, 32'h4444_0000, 1'b1);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    push_grant(3'b001, 5'd3, 32'h3333_0000, 1'b1);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    tick();

    // Clear sequence with requester 2 waiting
    n0 = cyc;
    iClearReq = 1'b1;
    set_req(2, 1'b1, 5'd7, 32'h0000_0077);
    push_clear(n0);
    @(negedge iCLK);
    check("clear_req_no_grant", 32'(oReqGrant), 32'h0);
    tick();
    iClearReq = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      @(negedge iCLK);
      check($sformatf("clear_busy_%0d", k), 32'(oBusy), 32'h1);
      if (k == 5) iClearReq = 1'b1;
      tick();
      iClearReq = 1'b0;
    end
    push_grant(3'b100, 5'd7, 32'h0000_0077, 1'b1);
    @(negedge iCLK);
    check("clear_done_busy", 32'(oBusy), 32'h0);
    tick();
    set_req(2, 1'b0, 5'd0, 32'h0);
    tick();
    tick();

    // Reset in the middle of a clear
    n0 = cyc;
    iClearReq = 1'b1;
    push_clear(n0);
    tick();
    iClearReq = 1'b0;
    repeat (9) tick();
    iRST_N = 1'b0;
    wq.delete();
    #1;
    check("midclr_busy", 32'(oBusy), 32'h0);
    check("midclr_regwrite", 32'(oRegWrite), 32'h0);
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(20 + i), rr_data[i] + 32'h1);
    tick();
    tick();
    iRST_N = 1'b1;
    push_grant(3'b001, 5'd20, rr_data[0] + 32'h1, 1'b1);
    tick();
    iReqValid = '0;
    tick();
    tick();

    check("grant_queue_drained", 32'(gq.size()), 32'h0);
    check("write_queue_drained", 32'(wq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
